spi_master: RTL and testbench



---
 rtl/spi_master.sv | 133 +++++++++++++
 tb/tb_spi_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: shifts a WIDTH-bit word out on mosi and in from miso, MSB first,
// generating sclk and csN from the system clock with CLKDIV system clocks per half-period.
module spi_master #(
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic [WIDTH-1:0] txData,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] rxData,
    output logic             sclk,
    output logic             csN,
    output logic             mosi,
    input  logic             miso
);

    localparam int CNT_W = $clog2(CLKDIV + 1);
    localparam int BIT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  divCnt_r;
    logic [BIT_W-1:0]  bitCnt_r;
    logic [WIDTH-1:0]  txShift_r;
    logic [WIDTH-1:0]  rxShift_r;
    logic [WIDTH-1:0]  txNext_s;
    logic [WIDTH-1:0]  rxNext_s;
    logic              halfDone_s;

    // Next-value helpers for the shift registers and the half-period terminal count.
    always_comb begin
        halfDone_s = (divCnt_r == CNT_W'(CLKDIV - 1));
        txNext_s   = txShift_r << 1'b1;
        rxNext_s   = (rxShift_r << 1'b1) | WIDTH'(miso);
    end

    // Transaction sequencer; bitCnt_r counts miso samples taken so far.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r   <= IDLE;
            divCnt_r  <= '0;
            bitCnt_r  <= '0;
            txShift_r <= '0;
            rxShift_r <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
            rxData    <= '0;
            sclk      <= 1'b0;
            csN       <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    ready <= 1'b1;
                    if (start) begin
                        txShift_r <= txData;
                        rxShift_r <= '0;
                        bitCnt_r  <= '0;
                        divCnt_r  <= '0;
                        csN       <= 1'b0;
                        mosi      <= txData[WIDTH-1];
                        ready     <= 1'b0;
                        state_r   <= LEAD;
                    end
                end
                LEAD: begin
                    if (halfDone_s) begin
                        divCnt_r  <= '0;
                        sclk      <= 1'b1;
                        rxShift_r <= rxNext_s;
                        bitCnt_r  <= bitCnt_r + BIT_W'(1);
                        state_r   <= HIGH;
                    end else begin
                        divCnt_r <= divCnt_r + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (halfDone_s) begin
                        divCnt_r <= '0;
                        sclk     <= 1'b0;
                        state_r  <= LOW;
                        // The last bit stays on mosi until csN rises.
                        if (bitCnt_r < BIT_W'(WIDTH)) begin
                            txShift_r <= txNext_s;
                            mosi      <= txNext_s[WIDTH-1];
                        end
                    end else begin
                        divCnt_r <= divCnt_r + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (halfDone_s) begin
                        divCnt_r <= '0;
                        if (bitCnt_r == BIT_W'(WIDTH)) begin
                            state_r <= IDLE;
                            csN     <= 1'b1;
                            mosi    <= 1'b0;
                            ready   <= 1'b1;
                            done    <= 1'b1;
                            rxData  <= rxShift_r;
                        end else begin
                            state_r   <= HIGH;
                            sclk      <= 1'b1;
                            rxShift_r <= rxNext_s;
                            bitCnt_r  <= bitCnt_r + BIT_W'(1);
                        end
                    end else begin
                        divCnt_r <= divCnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    divCnt_r <= '0;
                    ready    <= 1'b1;
                    sclk     <= 1'b0;
                    csN      <= 1'b1;
                    mosi     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: vector table, hand-written corner sequences and
// randomized transactions checked against a bit-level reference of the serial protocol.
module tb_spi_master;

    localparam int W = 8;
    localparam int D = 4;
    localparam int T = D * (1 + 2 * W);

    logic         clk;
    logic         resetN;
    logic         start;
    logic [W-1:0] txData;
    logic         ready;
    logic         done;
    logic [W-1:0] rxData;
    logic         sclk;
    logic         csN;
    logic         mosi;
    logic         miso;

    int           misoMode;
    logic [W-1:0] misoWord;
    int           misoIdx;

    int tests;
    int fails;

    typedef struct {
        logic [W-1:0] tx;
        int           mode;
        logic [W-1:0] mw;
        logic [W-1:0] expRx;
    } vec_t;

    vec_t vecs[4];

    spi_master #(.WIDTH(W), .CLKDIV(D)) dut (
        .clk    (clk),
        .resetN (resetN),
        .start  (start),
        .txData (txData),
        .ready  (ready),
        .done   (done),
        .rxData (rxData),
        .sclk   (sclk),
        .csN    (csN),
        .mosi   (mosi),
        .miso   (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: 0 loopback, 1 tied high, 2 tied low, 3 shifts out misoWord MSB first.
    assign miso = (misoMode == 0) ? mosi :
                  (misoMode == 1) ? 1'b1 :
                  (misoMode == 2) ? 1'b0 :
                  (misoIdx < W)   ? misoWord[W-1-misoIdx] : 1'b0;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] refRx(input logic [W-1:0] tx, input int mode, input logic [W-1:0] mw);
        case (mode)
            0:       return tx;
            1:       return '1;
            2:       return '0;
            default: return mw;
        endcase
    endfunction

    task automatic runTxn(input logic [W-1:0] tx, input int mode, input logic [W-1:0] mw,
                          input logic [W-1:0] expRx, input int pokeEdge, input bit hold);
        int   rises;
        int   doneEdge;
        int   csLow;
        logic prevSclk;
        misoMode = mode;
        misoWord = mw;
        misoIdx  = 0;
        txData   = tx;
        start    = 1'b1;
        @(posedge clk); #1;
        check("csFallAtEdge0", int'(csN), 0);
        check("mosiMsbAtEdge0", int'(mosi), int'((tx >> (W - 1)) & 1));
        check("readyLowAtEdge0", int'(ready), 0);
        if (!hold) start = 1'b0;
        rises    = 0;
        doneEdge = -1;
        csLow    = 1;
        prevSclk = sclk;
        for (int e = 1; e <= T + 4 && doneEdge < 0; e++) begin
            @(posedge clk); #1;
            if (!csN) csLow++;
            if (sclk && !prevSclk) begin
                check("sclkRiseEdge", e, D * (1 + 2 * rises));
                if (rises < W) check("mosiAtRise", int'(mosi), int'((tx >> (W - 1 - rises)) & 1));
                rises++;
                misoIdx = rises;
            end
            prevSclk = sclk;
            if (done) doneEdge = e;
            if (e + 1 == pokeEdge) begin
                start  = 1'b1;
                txData = 8'h3C;
            end
            if (e == pokeEdge) start = 1'b0;
        end
        check("sclkRiseCount", rises, W);
        check("doneEdge", doneEdge, T);
        check("csLowCycles", csLow, T);
        check("rxDataAtDone", int'(rxData), int'(expRx));
        check("csHighAtDone", int'(csN), 1);
        check("readyAtDone", int'(ready), 1);
        if (!hold) begin
            @(posedge clk); #1;
            check("doneOneCycle", int'(done), 0);
            check("rxDataHeld", int'(rxData), int'(expRx));
            check("noExtraStart", int'(csN), 1);
        end
    endtask

    initial begin
        int           r;
        logic [W-1:0] rtx;
        logic [W-1:0] rmw;
        int           rmode;
        tests    = 0;
        fails    = 0;
        misoMode = 0;
        misoWord = '0;
        misoIdx  = 0;
        txData   = 8'hA5;
        start    = 1'b1;
        resetN   = 1'b0;

        vecs[0] = '{tx: 8'hA5, mode: 0, mw: 8'h00, expRx: 8'hA5};
        vecs[1] = '{tx: 8'h00, mode: 1, mw: 8'h00, expRx: 8'hFF};
        vecs[2] = '{tx: 8'hFF, mode: 2, mw: 8'h00, expRx: 8'h00};
        vecs[3] = '{tx: 8'h96, mode: 3, mw: 8'h5C, expRx: 8'h5C};

        // Reset held with start high: outputs sit at reset values.
        repeat (3) begin
            @(posedge clk); #1;
            check("rstReady", int'(ready), 1);
            check("rstCsN", int'(csN), 1);
            check("rstSclk", int'(sclk), 0);
            check("rstMosi", int'(mosi), 0);
            check("rstDone", int'(done), 0);
            check("rstRxData", int'(rxData), 0);
        end
        start  = 1'b0;
        #2 resetN = 1'b1;
        @(posedge clk); #1;
        check("idleAfterRst", int'(csN), 1);

        for (int i = 0; i < 4; i++)
            runTxn(vecs[i].tx, vecs[i].mode, vecs[i].mw, vecs[i].expRx, -1, 1'b0);

        // Start pulse while busy must be ignored.
        runTxn(8'hA5, 0, 8'h00, 8'hA5, 20, 1'b0);

        // Back-to-back with start held high; second word presented at the done edge.
        runTxn(8'h81, 0, 8'h00, 8'h81, -1, 1'b1);
        runTxn(8'h7E, 0, 8'h00, 8'h7E, -1, 1'b0);

        // Asynchronous reset during bit 3.
        misoMode = 0;
        txData   = 8'hC3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        r = 0;
        for (int i = 0; i < 200 && r < 4; i++) begin
            @(posedge clk); #1;
            if (sclk && dut.sclk) r = (r < 4 && sclk) ? r : r;
            if (sclk) begin
                r++;
                while (sclk && r < 4) begin
                    @(posedge clk); #1;
                end
            end
        end
        check("reachedBit3", r, 4);
        #3 resetN = 1'b0;
        #1;
        check("asyncCsN", int'(csN), 1);
        check("asyncSclk", int'(sclk), 0);
        check("asyncMosi", int'(mosi), 0);
        check("asyncReady", int'(ready), 1);
        check("asyncRxData", int'(rxData), 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("asyncNoDone", int'(done), 0);
        end
        #2 resetN = 1'b1;
        @(posedge clk); #1;
        runTxn(8'h5A, 0, 8'h00, 8'h5A, -1, 1'b0);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 12; i++) begin
            rmode = int'($urandom_range(0, 3));
            rtx   = W'($urandom);
            rmw   = W'($urandom);
            runTxn(rtx, rmode, rmw, refRx(rtx, rmode, rmw), -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
